// File: rtl/io_in_pad_filter.sv
// Input pad front-end: per-channel synchroniser, debounce filter, edge pulses
// and a sticky flag for pulses the filter rejected.
module io_in_pad_filter #(
  parameter int WIDTH         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter bit INIT          = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] top_pin,
  input  logic             filter_en,
  input  logic             glitch_clr,
  output logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] glitch_seen
);

  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [CNT_W-1:0]       cnt_reg;
      logic [CNT_W-1:0]       cnt_next;
      logic                   pin_reg;
      logic                   pin_next;
      logic                   rise_reg;
      logic                   fall_reg;
      logic                   glitch_reg;
      logic                   glitch_next;
      logic                   s;

      // Plain flop chain; nothing may sit between stages.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_reg <= {SYNC_STAGES{INIT}};
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], top_pin[gi]};
        end
      end

      assign s = sync_reg[SYNC_STAGES-1];

      always_comb begin
        pin_next    = pin_reg;
        cnt_next    = '0;
        glitch_next = glitch_reg & ~glitch_clr;
        if (!filter_en) begin
          pin_next = s;
        end else if (s == pin_reg) begin
          // Level fell back before acceptance; a set overrides a same-cycle clear.
          if (cnt_reg != '0) begin
            glitch_next = 1'b1;
          end
        end else if (cnt_reg == CNT_LAST) begin
          pin_next = s;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pin_reg    <= INIT;
          cnt_reg    <= '0;
          rise_reg   <= 1'b0;
          fall_reg   <= 1'b0;
          glitch_reg <= 1'b0;
        end else begin
          pin_reg    <= pin_next;
          cnt_reg    <= cnt_next;
          rise_reg   <= pin_next & ~pin_reg;
          fall_reg   <= ~pin_next & pin_reg;
          glitch_reg <= glitch_next;
        end
      end

      assign pin[gi]         = pin_reg;
      assign rise[gi]        = rise_reg;
      assign fall[gi]        = fall_reg;
      assign glitch_seen[gi] = glitch_reg;
    end
  endgenerate

endmodule

// File: tb/tb_io_in_pad_filter.sv
// Scoreboard bench for io_in_pad_filter: a default build (FILTER_CYCLES=4)
// and a FILTER_CYCLES=1 build share the same stimulus.
module tb_io_in_pad_filter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] top_pin;
  logic       filter_en;
  logic       glitch_clr;
  logic [3:0] pin, rise, fall, glitch_seen;
  logic [3:0] pin1, rise1, fall1, glitch1;

  typedef struct packed {
    logic [3:0] pin;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] glitch;
    logic [3:0] pin1;
    logic [3:0] rise1;
    logic [3:0] fall1;
    logic [3:0] glitch1;
  } exp_t;

  exp_t sb[$];
  exp_t obs;
  exp_t exp_v;
  int   total = 0;
  int   bad   = 0;

  assign obs = {pin, rise, fall, glitch_seen, pin1, rise1, fall1, glitch1};

  always #5 clk = ~clk;

  io_in_pad_filter #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_CYCLES(4), .INIT(1'b0)) dut (
    .clk(clk), .rst(rst), .top_pin(top_pin), .filter_en(filter_en),
    .glitch_clr(glitch_clr), .pin(pin), .rise(rise), .fall(fall),
    .glitch_seen(glitch_seen)
  );

  io_in_pad_filter #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_CYCLES(1), .INIT(1'b0)) dut1 (
    .clk(clk), .rst(rst), .top_pin(top_pin), .filter_en(filter_en),
    .glitch_clr(glitch_clr), .pin(pin1), .rise(rise1), .fall(fall1),
    .glitch_seen(glitch1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; top_pin = 4'b0000; filter_en = 1'b1; glitch_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('0);
      step();
      exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL reset cycle %0d: got %h want %h", i, obs, exp_v);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_filtered_rise();
    for (int i = 0; i < 8; i++) begin
      if (i == 0) top_pin = 4'b0001;
      exp_v = '0;
      exp_v.pin   = (i >= 5) ? 4'b0001 : 4'b0000;
      exp_v.rise  = (i == 5) ? 4'b0001 : 4'b0000;
      exp_v.pin1  = (i >= 2) ? 4'b0001 : 4'b0000;
      exp_v.rise1 = (i == 2) ? 4'b0001 : 4'b0000;
      sb.push_back(exp_v);
      step();
      exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL filtered_rise edge %0d: got %h want %h", i + 1, obs, exp_v);
      end
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 9; i++) begin
      if (i == 0) top_pin = 4'b0011;
      if (i == 3) top_pin = 4'b0001;
      glitch_clr = (i == 8);
      exp_v = '0;
      exp_v.pin    = 4'b0001;
      exp_v.glitch = (i >= 5 && i < 8) ? 4'b0010 : 4'b0000;
      exp_v.pin1   = (i >= 2 && i < 5) ? 4'b0011 : 4'b0001;
      exp_v.rise1  = (i == 2) ? 4'b0010 : 4'b0000;
      exp_v.fall1  = (i == 5) ? 4'b0010 : 4'b0000;
      sb.push_back(exp_v);
      step();
      exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL glitch edge %0d: got %h want %h", i + 1, obs, exp_v);
      end
    end
    glitch_clr = 1'b0;
  endtask

  task automatic test_bypass();
    filter_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) top_pin = 4'b0101;
      if (i == 1) top_pin = 4'b0001;
      exp_v = '0;
      exp_v.pin  = (i == 2) ? 4'b0101 : 4'b0001;
      exp_v.rise = (i == 2) ? 4'b0100 : 4'b0000;
      exp_v.fall = (i == 3) ? 4'b0100 : 4'b0000;
      exp_v.pin1 = exp_v.pin; exp_v.rise1 = exp_v.rise; exp_v.fall1 = exp_v.fall;
      sb.push_back(exp_v);
      step();
      exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL bypass edge %0d: got %h want %h", i + 1, obs, exp_v);
      end
    end
    filter_en = 1'b1;
  endtask

  task automatic test_en_toggle();
    for (int i = 0; i < 6; i++) begin
      if (i == 0) top_pin = 4'b0101;
      if (i == 2) top_pin = 4'b0001;
      filter_en = (i != 4);
      exp_v = '0;
      exp_v.pin   = 4'b0001;
      exp_v.pin1  = (i == 2 || i == 3) ? 4'b0101 : 4'b0001;
      exp_v.rise1 = (i == 2) ? 4'b0100 : 4'b0000;
      exp_v.fall1 = (i == 4) ? 4'b0100 : 4'b0000;
      sb.push_back(exp_v);
      step();
      exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL en_toggle edge %0d: got %h want %h", i + 1, obs, exp_v);
      end
    end
    filter_en = 1'b1;
  endtask

  task automatic test_reset_midcount();
    for (int i = 0; i < 21; i++) begin
      if (i == 0)  top_pin = 4'b1111;
      if (i == 7)  top_pin = 4'b0000;
      if (i == 11) top_pin = 4'b1111;
      if (i == 14) rst = 1'b0;
      exp_v = '0;
      if (i < 5)       exp_v.pin = 4'b0001;
      else if (i < 11) exp_v.pin = 4'b1111;
      else if (i >= 19) exp_v.pin = 4'b1111;
      exp_v.rise = (i == 5) ? 4'b1110 : (i == 19) ? 4'b1111 : 4'b0000;
      if (i < 2)        exp_v.pin1 = 4'b0001;
      else if (i < 9)   exp_v.pin1 = 4'b1111;
      else if (i >= 16) exp_v.pin1 = 4'b1111;
      exp_v.rise1 = (i == 2) ? 4'b1110 : (i == 16) ? 4'b1111 : 4'b0000;
      exp_v.fall1 = (i == 9) ? 4'b1111 : 4'b0000;
      sb.push_back(exp_v);
      if (i == 11) begin
        #2 rst = 1'b1;
        #1;
      end else begin
        step();
      end
      exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL reset_midcount step %0d: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_same_cycle_clr();
    for (int i = 0; i < 6; i++) begin
      if (i == 0) top_pin = 4'b0011;
      if (i == 1) top_pin = 4'b0111;
      if (i == 2) top_pin = 4'b1111;
      glitch_clr = (i == 4);
      exp_v = '0;
      exp_v.pin    = 4'b1111;
      exp_v.glitch = (i == 3) ? 4'b0100 : (i >= 4) ? 4'b1000 : 4'b0000;
      case (i)
        2:       exp_v.pin1 = 4'b0011;
        3:       exp_v.pin1 = 4'b0111;
        default: exp_v.pin1 = 4'b1111;
      endcase
      exp_v.fall1 = (i == 2) ? 4'b1100 : 4'b0000;
      exp_v.rise1 = (i == 3) ? 4'b0100 : (i == 4) ? 4'b1000 : 4'b0000;
      sb.push_back(exp_v);
      step();
      exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL same_cycle_clr edge %0d: got %h want %h", i + 1, obs, exp_v);
      end
    end
    glitch_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_filtered_rise();
    test_glitch();
    test_bypass();
    test_en_toggle();
    test_reset_midcount();
    test_same_cycle_clr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
